// File: rtl/step_chain_if.sv
// step_chain_if: operand/result handshake bundle for step_chain_seq
// Signals: in_valid/in_ready/in_a..in_d (operand load), out_valid/out_ready/out_a..out_d (result),
// busy and step (status), abort (only when STEP_CHAIN_ABORT_EN is defined).
// The slave modport is the sequencer side; the master modport is the source/consumer side.
interface step_chain_if #(parameter int W = 32);
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] in_a, in_b, in_c, in_d;
    logic [W-1:0] out_a, out_b, out_c, out_d;
    logic [1:0]   step;
`ifdef STEP_CHAIN_ABORT_EN
    logic         abort;
    modport slave (input in_valid, in_a, in_b, in_c, in_d, out_ready, abort,
                   output in_ready, out_valid, out_a, out_b, out_c, out_d, busy, step);
    modport master (output in_valid, in_a, in_b, in_c, in_d, out_ready, abort,
                    input in_ready, out_valid, out_a, out_b, out_c, out_d, busy, step);
`else
    modport slave (input in_valid, in_a, in_b, in_c, in_d, out_ready,
                   output in_ready, out_valid, out_a, out_b, out_c, out_d, busy, step);
    modport master (output in_valid, in_a, in_b, in_c, in_d, out_ready,
                    input in_ready, out_valid, out_a, out_b, out_c, out_d, busy, step);
`endif
endinterface

// File: rtl/step_chain_seq.sv
// step_chain_seq: timed sequencer for the chain a=b+c, d=a-3, b=d+10, c=c+1, repeated ITER times
// Ports: clk, rst (async active-high), bus (step_chain_if.slave: load handshake, result handshake,
// busy/step status). Optional feature macro STEP_CHAIN_ABORT_EN adds bus.abort (RUN/HOLD -> IDLE).
module step_chain_seq #(
    parameter int W        = 32,
    parameter int ITER     = 4,
    parameter int STEP_CYC = 5
) (
    input logic         clk,
    input logic         rst,
    step_chain_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam int CW = STEP_CYC > 1 ? $clog2(STEP_CYC) : 1;
    localparam int IW = $clog2(ITER + 1);
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    step_q, step_n;
    logic [IW-1:0] it, it_n;
    logic [W-1:0]  a, b, c, d, a_n, b_n, c_n, d_n;
    logic          fire;
    assign fire = state == RUN && cnt == CW'(STEP_CYC - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            step_q <= '0;
            it     <= '0;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            d      <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            step_q <= step_n;
            it     <= it_n;
            a      <= a_n;
            b      <= b_n;
            c      <= c_n;
            d      <= d_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step_n  = step_q;
        it_n    = it;
        a_n     = a;
        b_n     = b;
        c_n     = c;
        d_n     = d;
        if (state == IDLE && bus.in_valid) begin
            state_n = RUN;
            cnt_n   = '0;
            step_n  = '0;
            it_n    = '0;
            a_n     = bus.in_a;
            b_n     = bus.in_b;
            c_n     = bus.in_c;
            d_n     = bus.in_d;
        end else if (state == RUN) begin
            cnt_n = fire ? '0 : cnt + 1'b1;
            if (fire) begin
                step_n  = step_q + 2'd1;
                a_n     = step_q == 2'd0 ? b + c : a;
                d_n     = step_q == 2'd1 ? a - W'(3) : d;
                b_n     = step_q == 2'd2 ? d + W'(10) : b;
                c_n     = step_q == 2'd3 ? c + W'(1) : c;
                it_n    = step_q == 2'd3 ? it + 1'b1 : it;
                state_n = step_q == 2'd3 && it_n == IW'(ITER) ? HOLD : RUN;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state_n = IDLE;
        end
`ifdef STEP_CHAIN_ABORT_EN
        // Abort discards the pending step so the registers keep their partial values.
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            cnt_n   = '0;
            step_n  = '0;
            it_n    = '0;
            a_n     = a;
            b_n     = b;
            c_n     = c;
            d_n     = d;
        end
`endif
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == HOLD;
    assign bus.busy      = state == RUN;
    assign bus.step      = step_q;
    assign bus.out_a     = a;
    assign bus.out_b     = b;
    assign bus.out_c     = c;
    assign bus.out_d     = d;
endmodule

// File: tb/tb_step_chain_seq.sv
// tb_step_chain_seq: vector table, corner sequences and randomized checks against a chain model
module tb_step_chain_seq;
    localparam int N0 = 4 * 4 * 5;
    localparam int N1 = 4 * 1 * 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    step_chain_if #(.W(32)) if0 ();
    step_chain_if #(.W(8))  if1 ();
    step_chain_seq #(.W(32), .ITER(4), .STEP_CYC(5)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    step_chain_seq #(.W(8),  .ITER(1), .STEP_CYC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    logic        iv [2];
    logic        ordy [2];
    logic [31:0] ia [2], ib [2], ic [2], id [2];
    logic        ir [2], ov [2], bz [2];
    logic [1:0]  stp [2];
    logic [31:0] oa [2], ob [2], oc [2], od [2];
    assign if0.in_valid = iv[0];
    assign if0.out_ready = ordy[0];
    assign if0.in_a = ia[0];
    assign if0.in_b = ib[0];
    assign if0.in_c = ic[0];
    assign if0.in_d = id[0];
    assign if1.in_valid = iv[1];
    assign if1.out_ready = ordy[1];
    assign if1.in_a = ia[1][7:0];
    assign if1.in_b = ib[1][7:0];
    assign if1.in_c = ic[1][7:0];
    assign if1.in_d = id[1][7:0];
    assign ir[0] = if0.in_ready;
    assign ov[0] = if0.out_valid;
    assign bz[0] = if0.busy;
    assign stp[0] = if0.step;
    assign oa[0] = if0.out_a;
    assign ob[0] = if0.out_b;
    assign oc[0] = if0.out_c;
    assign od[0] = if0.out_d;
    assign ir[1] = if1.in_ready;
    assign ov[1] = if1.out_valid;
    assign bz[1] = if1.busy;
    assign stp[1] = if1.step;
    assign oa[1] = 32'(if1.out_a);
    assign ob[1] = 32'(if1.out_b);
    assign oc[1] = 32'(if1.out_c);
    assign od[1] = 32'(if1.out_d);
`ifdef STEP_CHAIN_ABORT_EN
    logic ab = 1'b0;
    assign if0.abort = ab;
    assign if1.abort = 1'b0;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: iterate the four assignments with plain arithmetic, truncating to w bits.
    task automatic model(input int w, input int iter, input logic [31:0] a0, b0, c0, d0,
                         output logic [31:0] a, b, c, d);
        logic [31:0] m;
        m = w == 32 ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        a = a0 & m; b = b0 & m; c = c0 & m; d = d0 & m;
        for (int k = 0; k < iter; k++) begin
            a = (b + c) & m;
            d = (a - 32'd3) & m;
            b = (d + 32'd10) & m;
            c = (c + 32'd1) & m;
        end
    endtask

    task automatic chk_vals(input int sel, input string name, input logic [31:0] ea, eb, ec, ed);
        chk({name, "_a"}, oa[sel], ea);
        chk({name, "_b"}, ob[sel], eb);
        chk({name, "_c"}, oc[sel], ec);
        chk({name, "_d"}, od[sel], ed);
    endtask

    task automatic txn(input int sel, input logic [31:0] a, b, c, d, ea, eb, ec, ed, input int hw);
        int n;
        int lat;
        lat = sel == 1 ? N1 : N0;
        ordy[sel] = hw == 0;
        chk("in_ready_idle", 32'(ir[sel]), 32'd1);
        ia[sel] = a; ib[sel] = b; ic[sel] = c; id[sel] = d;
        iv[sel] = 1'b1;
        @(negedge clk);
        iv[sel] = 1'b0;
        chk("run_status", {30'd0, ir[sel], bz[sel]}, 32'd1);
        n = 0;
        while (!ov[sel] && n < lat + 10) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        for (int i = 0; i < hw; i++) begin
            chk("hold_status", {29'd0, ov[sel], ir[sel], bz[sel]}, 32'd4);
            chk_vals(sel, "hold", ea, eb, ec, ed);
            iv[sel] = 1'($urandom_range(0, 1));
            ia[sel] = $urandom;
            @(negedge clk);
        end
        chk_vals(sel, "result", ea, eb, ec, ed);
        iv[sel] = 1'b0;
        ordy[sel] = 1'b1;
        @(negedge clk);
        chk("release", {30'd0, ov[sel], ir[sel]}, 32'd1);
        chk_vals(sel, "after_release", ea, eb, ec, ed);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] a, b, c, d, ea, eb, ec, ed;
        int          hw;
    } vec_t;

    initial begin
        vec_t vt [6];
        logic [31:0] ra, rb, rc, rd, ea, eb, ec, ed;
        vt[0] = '{0, 30, 20, 15, 5, 107, 114, 19, 104, 0};
        vt[1] = '{0, 30, 20, 15, 5, 107, 114, 19, 104, 10};
        vt[2] = '{0, 0, 0, 0, 0, 27, 34, 4, 24, 1};
        vt[3] = '{0, 0, 32'hFFFF_FFF0, 0, 0, 11, 18, 4, 8, 3};
        vt[4] = '{1, 0, 250, 10, 0, 4, 11, 11, 1, 0};
        vt[5] = '{1, 0, 0, 0, 0, 0, 7, 1, 32'hFD, 2};
        for (int s = 0; s < 2; s++) begin
            iv[s] = 1'b0; ordy[s] = 1'b0;
            ia[s] = '0; ib[s] = '0; ic[s] = '0; id[s] = '0;
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_status", {28'd0, ir[s], ov[s], bz[s], 1'b0}, 32'd8);
            chk("reset_step", 32'(stp[s]), 32'd0);
            chk_vals(s, "reset", 0, 0, 0, 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        foreach (vt[i])
            txn(vt[i].sel, vt[i].a, vt[i].b, vt[i].c, vt[i].d,
                vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ed, vt[i].hw);
        // Reset 40 cycles into a default run.
        ia[0] = 30; ib[0] = 20; ic[0] = 15; id[0] = 5;
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (39) @(negedge clk);
        chk("mid_run_busy", 32'(bz[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_status", {29'd0, ir[0], ov[0], bz[0]}, 32'd4);
        chk_vals(0, "async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(0, 30, 20, 15, 5, 107, 114, 19, 104, 0);
`ifdef STEP_CHAIN_ABORT_EN
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (11) @(negedge clk);
        ab = 1'b1;
        @(negedge clk);
        ab = 1'b0;
        chk("abort_status", {28'd0, ir[0], ov[0], bz[0], 1'b0}, 32'd8);
        chk("abort_step", 32'(stp[0]), 32'd0);
        chk_vals(0, "abort", 35, 20, 15, 32);
        begin
            int seen = 0;
            for (int i = 0; i < 100; i++) begin
                if (ov[0]) seen++;
                @(negedge clk);
            end
            chk("abort_no_valid", 32'(seen), 32'd0);
        end
`endif
        for (int r = 0; r < 12; r++) begin
            int s;
            s = r % 2;
            ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
            model(s == 1 ? 8 : 32, s == 1 ? 1 : 4, ra, rb, rc, rd, ea, eb, ec, ed);
            txn(s, ra, rb, rc, rd, ea, eb, ec, ed, int'($urandom_range(0, 3)));
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/step_chain_seq.md
# step_chain_seq

Clocked, synthesizable sequencer for the four-step integer update chain a=b+c, d=a-3, b=d+10, c=c+1. Each step is applied after a programmable delay, and the chain repeats a programmable number of iterations. It sits between an operand source (valid/ready input) and a result consumer (valid/ready output). It loads a/b/c/d in one handshake, runs the chain, then holds the final values until the consumer accepts them.

## Interface
- W, 32, data width of a/b/c/d; two's complement; W ≥ 4
- ITER, 4, full chain iterations per transaction; ITER ≥ 1
- STEP_CYC, 5, clock cycles between consecutive steps; STEP_CYC ≥ 1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept operands; high exactly in IDLE
- in_a, in_b, in_c, in_d  input  W each  initial values
- out_valid  output  1  final values present; high exactly in HOLD
- out_ready  input  1  consumer accepts result
- out_a, out_b, out_c, out_d  output  W each  working registers, driven directly
- busy  output  1  high exactly in RUN
- step  output  2  index of the next step to apply (0..3)
- abort  input  1  present only with STEP_CHAIN_ABORT_EN

## Operation
- States: IDLE, RUN, HOLD.
- IDLE:
  - in_valid & in_ready at an edge loads in_a..in_d into the working registers.
  - At that edge: delay counter cnt=0, step=0, iteration counter it=0, go to RUN.
- RUN:
  - cnt increments each cycle.
  - At the edge where cnt==STEP_CYC-1: apply the op selected by step, then set cnt=0 and step=step+1 (mod 4).
  - step 0: a ← b+c
  - step 1: d ← a-3, using a as updated in step 0
  - step 2: b ← d+10
  - step 3: c ← c+1; it ← it+1
  - When step 3 completes with it reaching ITER: go to HOLD on the same edge.
- HOLD:
  - Working registers are frozen.
  - out_valid & out_ready at an edge moves to IDLE; registers keep their values.
- Arithmetic:
  - All ops are modulo 2^W; overflow wraps silently.
  - Constants 3, 10 and 1 are zero-extended to W.
- in_valid is ignored outside IDLE. out_ready is ignored outside HOLD.
- out_a..out_d change only at step edges or at a load. They are meaningful to the consumer only while out_valid=1.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE, cnt=0, step=0, it=0.
  - All working registers 0, so out_a..out_d = 0.
  - in_ready=1, out_valid=0, busy=0.
- Reset mid-RUN or mid-HOLD abandons the transaction. No partial result is presented.
- Latency: with the load edge at T0, step k (1-based) is applied at edge T0 + k·STEP_CYC.
  - out_valid rises after edge T0 + 4·ITER·STEP_CYC.
  - With defaults, this is 80 cycles.
- STEP_CYC=1: one step per clock. There are no idle cycles inside RUN.
- The HOLD→IDLE edge raises in_ready the next cycle. No same-cycle reload, so the minimum load-to-load spacing is 4·ITER·STEP_CYC + 2 cycles.
- out_valid stays high and outputs stay stable under any length of out_ready=0.

## Configuration
- STEP_CHAIN_ABORT_EN defined:
  - Adds the abort input.
  - abort=1 at an edge in RUN or HOLD forces IDLE, with cnt, step and it cleared.
  - Working registers keep their current partial values, and out_valid does not assert.
  - abort in IDLE has no effect.
  - If abort and in_valid are both high in IDLE, the load happens.
- STEP_CHAIN_ABORT_EN undefined: no abort port; a transaction always runs to HOLD.

## Test plan
- Defaults, load a=30 b=20 c=15 d=5, out_ready=1 → out_valid after exactly 80 cycles with a=107 b=114 c=19 d=104. Then in_ready=1 on the following cycle.
- Same load, out_ready=0 for 10 cycles in HOLD → out_valid and values stable, in_ready=0, in_valid pulses ignored; accepted on the first out_ready=1 edge.
- W=8, ITER=1, STEP_CYC=1, load a=0 b=250 c=10 d=0 → wrap: a=4 d=1 b=11 c=11 after 4 cycles.
- ITER=1, load all zeros → a=0, d=0xFFFFFFFD (−3), b=7, c=1.
- Assert rst for 1 cycle at cycle 40 of a default run → all outputs 0, in_ready=1 immediately. A subsequent load of 30/20/15/5 yields 107/114/19/104.
- STEP_CHAIN_ABORT_EN: abort at cycle 12 of the default run → IDLE next cycle, out_valid never rises, out_a=35 out_d=32 (b and c unchanged at 20/15).
